// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared definitions for the FIFO write arbiter.
//   arb_state_e  : arbiter FSM state encoding (ARB_IDLE, ARB_GRANT)
//   arb_id_width : index width for n requesters, never less than 1 bit
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    function automatic int arb_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner selection.
// The search starts one past last_idx and ascends with wrap-around;
// the winner is the first index whose request bit is set.
// Ports:
//   req      in  [N_REQ-1:0] request vector
//   last_idx in  [ID_W-1:0]  most recently granted index
//   winner   out [ID_W-1:0]  selected index (0 when no request)
//   any      out             at least one request is set
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = arb_id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_idx,
    output logic [ID_W-1:0]  winner,
    output logic             any
);

    int unsigned idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = (32'(last_idx) + i) % 32'(N_REQ);
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter merging N_REQ packet streams into the
// write port of a downstream synchronous FIFO (FIFO instantiated by parent).
// Optional macro FIFO_WR_ARB_TAG_EN: prepend the granted index to each
// written word as {grant_id, payload}.
// Ports:
//   clk          in                 rising-edge clock
//   rst_n        in                 synchronous active-low reset
//   req_valid    in  [N_REQ-1:0]    per-requester beat valid
//   req_data     in  [N_REQ*DATA_W] requester i at [i*DATA_W +: DATA_W]
//   req_last     in  [N_REQ-1:0]    per-requester last beat of packet
//   req_ready    out [N_REQ-1:0]    beat accepted when valid & ready
//   fifo_wr_en   out                FIFO write strobe
//   fifo_wr_data out [FIFO_W-1:0]   FIFO write data
//   fifo_full    in                 FIFO full flag
//   grant_id     out [ID_W-1:0]     currently granted requester
//   busy         out                high while a grant is held
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int DATA_W    = 32,
    parameter  int MAX_BURST = 8,
    localparam int ID_W      = arb_id_width(N_REQ),
`ifdef FIFO_WR_ARB_TAG_EN
    localparam int FIFO_W    = DATA_W + ID_W
`else
    localparam int FIFO_W    = DATA_W
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    fifo_wr_en,
    output logic [FIFO_W-1:0]       fifo_wr_data,
    input  logic                    fifo_full,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy
);

    localparam int CNT_W = arb_id_width(MAX_BURST);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]  last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [ID_W-1:0]  rr_winner;
    logic             rr_any;
    logic [DATA_W-1:0] payload;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req      (req_valid),
        .last_idx (last_q),
        .winner   (rr_winner),
        .any      (rr_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= ID_W'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (rr_any) begin
                    grant_d = rr_winner;
                    cnt_d   = '0;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                // rst_n gates the handshake so the reset cycle itself
                // never accepts a beat from the abandoned packet.
                req_ready[grant_q] = !fifo_full && rst_n;
                fifo_wr_en         = req_valid[grant_q] && req_ready[grant_q];
                if (fifo_wr_en) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (req_last[grant_q] || cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d = ARB_IDLE;
                        last_d  = grant_q;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign payload  = req_data[grant_q*DATA_W +: DATA_W];
    assign grant_id = grant_q;
    assign busy     = (state_q == ARB_GRANT);

`ifdef FIFO_WR_ARB_TAG_EN
    assign fifo_wr_data = {grant_q, payload};
`else
    assign fifo_wr_data = payload;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
module tb_fifo_wr_arb;

    localparam int N_REQ     = 4;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 8;
    localparam int ID_W      = 2;
`ifdef FIFO_WR_ARB_TAG_EN
    localparam int FIFO_W    = DATA_W + ID_W;
`else
    localparam int FIFO_W    = DATA_W;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_wr_en;
    logic [FIFO_W-1:0]       fifo_wr_data;
    logic                    fifo_full;
    logic [ID_W-1:0]         grant_id;
    logic                    busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fifo_wr_arb #(
        .N_REQ     (N_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [DATA_W-1:0] v);
        req_data[i*DATA_W +: DATA_W] = v;
    endtask

    function automatic logic [DATA_W-1:0] slot(input int i);
        return req_data[i*DATA_W +: DATA_W];
    endfunction

    function automatic logic [FIFO_W-1:0] ew(input int id, input logic [DATA_W-1:0] p);
`ifdef FIFO_WR_ARB_TAG_EN
        return {ID_W'(id), p};
`else
        return p;
`endif
    endfunction

    task automatic check_out(input string tag, input logic exp_busy, input int exp_grant,
                             input logic [N_REQ-1:0] exp_ready, input logic exp_wr,
                             input logic [FIFO_W-1:0] exp_data);
        #1;
        chk({tag, ".busy"},  64'(busy),       64'(exp_busy));
        chk({tag, ".grant"}, 64'(grant_id),   64'(exp_grant));
        chk({tag, ".ready"}, 64'(req_ready),  64'(exp_ready));
        chk({tag, ".wr_en"}, 64'(fifo_wr_en), 64'(exp_wr));
        if (exp_busy)
            chk({tag, ".data"}, 64'(fifo_wr_data), 64'(exp_data));
    endtask

    initial begin
        int g_id [5];
        int g_n  [5];
        int prev;
        int n1;

        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_data(i, 32'hA000_0000 | 32'(i));

        // reset, with all requesters already asserting valid
        step();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        check_out("in_reset", 1'b0, 0, 4'b0000, 1'b0, '0);
        step();
        rst_n = 1'b1;
        check_out("after_reset", 1'b0, 0, 4'b0000, 1'b0, '0);

        // all valid, single-beat packets: grants 0,1,2,3,0, one write per 2 cycles
        for (int k = 0; k < 5; k++) begin
            if (k > 0) check_out("rr_idle", 1'b0, (k - 1) % 4, 4'b0000, 1'b0, '0);
            step();
            check_out("rr_grant", 1'b1, k % 4, 4'(1 << (k % 4)), 1'b1, ew(k % 4, slot(k % 4)));
            step();
        end
        req_valid = '0;
        check_out("idle_hold", 1'b0, 0, 4'b0000, 1'b0, '0);
        step();
        check_out("idle_hold2", 1'b0, 0, 4'b0000, 1'b0, '0);

        // req 2 three-beat packet while req 0 waits (last_grant = 0)
        req_valid = 4'b0101;
        req_last  = 4'b0001;
        set_data(2, 32'h2222_0000);
        step();
        for (int b = 0; b < 3; b++) begin
            req_last[2] = (b == 2);
            set_data(2, 32'h2222_0000 + 32'(b));
            check_out("pkt_beat", 1'b1, 2, 4'b0100, 1'b1, ew(2, 32'h2222_0000 + 32'(b)));
            step();
        end
        check_out("pkt_end", 1'b0, 2, 4'b0000, 1'b0, '0);
        step();
        check_out("pkt_next", 1'b1, 0, 4'b0001, 1'b1, ew(0, 32'hA000_0000));
        step();
        req_valid = '0;
        req_last  = '0;

        // req 3 packet with fifo_full for 5 cycles mid-packet
        req_valid = 4'b1000;
        set_data(3, 32'hDEAD_BEEF);
        step();
        check_out("full_b0", 1'b1, 3, 4'b1000, 1'b1, ew(3, 32'hDEAD_BEEF));
        step();
        set_data(3, 32'h3333_0001);
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check_out("full_stall", 1'b1, 3, 4'b0000, 1'b0, ew(3, 32'h3333_0001));
            step();
        end
        fifo_full = 1'b0;
        check_out("full_resume", 1'b1, 3, 4'b1000, 1'b1, ew(3, 32'h3333_0001));
        step();
        set_data(3, 32'h3333_0002);
        req_last[3] = 1'b1;
        check_out("full_last", 1'b1, 3, 4'b1000, 1'b1, ew(3, 32'h3333_0002));
        step();
        check_out("full_end", 1'b0, 3, 4'b0000, 1'b0, '0);
        req_valid = '0;
        req_last  = '0;

        // req 1 streams 20 beats without last, req 3 single beats: 1(8),3,1(8),3,1(4)
        g_id = '{1, 3, 1, 3, 1};
        g_n  = '{8, 1, 8, 1, 4};
        prev = 3;
        n1   = 0;
        req_valid = 4'b1010;
        req_last  = 4'b1000;
        set_data(3, 32'h3333_AAAA);
        set_data(1, 32'h1111_0000);
        for (int gi = 0; gi < 5; gi++) begin
            check_out("burst_idle", 1'b0, prev, 4'b0000, 1'b0, '0);
            step();
            for (int b = 0; b < g_n[gi]; b++) begin
                check_out("burst_beat", 1'b1, g_id[gi], 4'(1 << g_id[gi]), 1'b1,
                          ew(g_id[gi], (g_id[gi] == 1) ? 32'h1111_0000 + 32'(n1) : 32'h3333_AAAA));
                step();
                if (g_id[gi] == 1) begin
                    n1++;
                    set_data(1, 32'h1111_0000 + 32'(n1));
                end
            end
            prev = g_id[gi];
        end
        chk("burst_total", 64'(n1), 64'd20);
        // requester 1 stalls mid-packet: grant is held, req 3 keeps waiting
        req_valid[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_out("hold", 1'b1, 1, 4'b0010, 1'b0, ew(1, 32'h1111_0014));
            step();
        end
        req_valid[1] = 1'b1;
        req_last[1]  = 1'b1;
        check_out("hold_last", 1'b1, 1, 4'b0010, 1'b1, ew(1, 32'h1111_0014));
        step();
        check_out("hold_end", 1'b0, 1, 4'b0000, 1'b0, '0);
        req_valid = '0;
        req_last  = '0;

        // reset for one cycle in the middle of a req 2 packet
        req_valid = 4'b0100;
        set_data(2, 32'h5555_0000);
        step();
        check_out("rst_b0", 1'b1, 2, 4'b0100, 1'b1, ew(2, 32'h5555_0000));
        step();
        rst_n = 1'b0;
        check_out("rst_in", 1'b1, 2, 4'b0000, 1'b0, ew(2, 32'h5555_0000));
        step();
        rst_n     = 1'b1;
        req_valid = 4'b0110;
        check_out("rst_after", 1'b0, 0, 4'b0000, 1'b0, '0);
        step();
        check_out("rst_next", 1'b1, 1, 4'b0010, 1'b1, ew(1, slot(1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, 2..16.
REQ-002 SHALL have parameter DATA_W, default 32: payload width per requester.
REQ-003 SHALL have parameter MAX_BURST, default 8: maximum beats per grant, 1..256.
REQ-004 SHALL have localparam ID_W = max(1, $clog2(N_REQ)).
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port req_valid, input, N_REQ: per-requester beat valid.
REQ-008 SHALL have port req_data, input, N_REQ*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port req_last, input, N_REQ: per-requester last beat of packet.
REQ-010 SHALL have port req_ready, output, N_REQ: per-requester beat accepted when valid&ready.
REQ-011 SHALL have port fifo_wr_en, output, 1: write strobe to downstream sync FIFO.
REQ-012 SHALL have port fifo_wr_data, output, FIFO_W: FIFO_W = DATA_W, or DATA_W+ID_W with FIFO_WR_ARB_TAG_EN.
REQ-013 SHALL have port fifo_full, input, 1: downstream FIFO full flag.
REQ-014 SHALL have port grant_id, output, ID_W: currently granted requester index.
REQ-015 SHALL have port busy, output, 1: high in GRANT state.

Function
REQ-016 SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-017 In IDLE with any req_valid high, SHALL register the round-robin winner into grant_id and go to GRANT next cycle; no beat transfers in IDLE.
REQ-018 The round-robin search SHALL start at (last_grant+1) mod N_REQ and ascend with wrap-around; it is the first index with req_valid high.
REQ-019 In IDLE with no req_valid high, SHALL remain in IDLE, with grant_id held.
REQ-020 In GRANT, req_ready[grant_id] SHALL equal !fifo_full; all other req_ready bits SHALL be 0; in IDLE all req_ready SHALL be 0.
REQ-021 fifo_wr_en SHALL equal req_valid[grant_id] & req_ready[grant_id], combinationally, with zero added latency.
REQ-022 fifo_wr_data SHALL equal req_data slice of grant_id, combinationally.
REQ-023 fifo_wr_en SHALL never assert while fifo_full is high.
REQ-024 A beat counter SHALL increment per accepted beat in GRANT and clear on entry to GRANT.
REQ-025 On an accepted beat with req_last high or beat count == MAX_BURST-1, SHALL go to IDLE, last_grant <= grant_id.
REQ-026 If req_valid[grant_id] drops mid-packet, SHALL hold GRANT indefinitely (no timeout); other requesters wait.
REQ-027 A packet longer than MAX_BURST SHALL be split; its remainder re-arbitrates as a new request.
REQ-028 Worst-case wait for a valid requester SHALL be (N_REQ-1) grants.

Reset
REQ-029 On rst_n low at a clk edge, SHALL enter IDLE, beat count 0, grant_id 0, last_grant N_REQ-1 (requester 0 wins first), busy 0.
REQ-030 While in reset and immediately after, req_ready and fifo_wr_en SHALL be 0.
REQ-031 Reset mid-packet SHALL abandon the packet without an extra write; the FIFO is reset by the same rst_n.

Configuration
REQ-032 Macro FIFO_WR_ARB_TAG_EN defined: fifo_wr_data = {grant_id, payload}; payload occupies the LSBs and the ID occupies the top ID_W bits.
REQ-033 Macro FIFO_WR_ARB_TAG_EN undefined: fifo_wr_data = payload only, width DATA_W; no tag logic is present.

Structure
REQ-034 A shared package fifo_arb_pkg SHALL hold the FSM state enum (ARB_IDLE, ARB_GRANT) and the arbitration-width function.
REQ-035 Round-robin winner selection SHALL be a sub-module rr_pick (inputs: request vector, last index; output: winner index, any flag), purely combinational.
REQ-036 The downstream FIFO SHALL be instantiated by the parent, not inside this block.

Verification
REQ-037 After reset, req_valid=4'b1111, 1-beat packets all last, fifo_full=0 -> grant order 0,1,2,3,0; one write every 2 cycles.
REQ-038 Req 2 sends a 3-beat packet while req 0 is valid -> 3 consecutive writes of req 2's data; req 0 is granted only after req 2's last beat.
REQ-039 fifo_full=1 for 5 cycles mid-packet -> req_ready and fifo_wr_en stay 0 for those cycles, data is not lost, and the packet resumes when full drops.
REQ-040 MAX_BURST=8, req 1 streams 20 beats without last, req 3 valid -> grants 1(8),3,1(8),3,1(4).
REQ-041 rst_n low for 1 cycle mid-packet -> next cycle busy=0 and no write; the next grant goes to the lowest valid index.
REQ-042 With TAG_EN, a req 3 beat 0xDEADBEEF -> fifo_wr_data = {2'd3, 32'hDEADBEEF}.
